// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and ALU control words for the ALU sequencer.
package alu_seq_pkg;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_SLT = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;

   localparam int MUL_ITER = 32;
   localparam int CNT_W    = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Field order gives the literal encoding {op1, op2, sub, cin}
   typedef struct packed {
      logic op1;
      logic op2;
      logic sub;
      logic cin;
   } alu_ctrl_t;

   localparam alu_ctrl_t CTRL_AND = alu_ctrl_t'(4'b0000);
   localparam alu_ctrl_t CTRL_OR  = alu_ctrl_t'(4'b0100);
   localparam alu_ctrl_t CTRL_ADD = alu_ctrl_t'(4'b1000);
   localparam alu_ctrl_t CTRL_SUB = alu_ctrl_t'(4'b1011);

   function automatic alu_ctrl_t ctrl_for_op(input logic [2:0] op);
      case (op)
         OP_OR:          return CTRL_OR;
         OP_ADD:         return CTRL_ADD;
         OP_SUB, OP_SLT: return CTRL_SUB;
         default:        return CTRL_AND;
      endcase
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/thirty_two_alu.sv
// 32-bit ripple ALU: AND / OR / sum / less selected by {op1, op2}, with b-invert and carry-in.
module thirty_two_alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op1,
   input  logic        op2,
   input  logic        sub,
   input  logic        cin,
   input  logic        less,
   output logic [31:0] result,
   output logic        sum31,
   output logic        cout
);

   logic [32:0] carry;
   logic [31:0] b_eff;
   logic [31:0] sum;
   logic [31:0] less_v;

   assign carry[0] = cin;
   assign b_eff    = b ^ {32{sub}};
   assign less_v   = {31'b0, less};

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_bit
         assign sum[gi]       = a[gi] ^ b_eff[gi] ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
         assign result[gi]    = op1 ? (op2 ? less_v[gi] : sum[gi])
                                    : (op2 ? (a[gi] | b_eff[gi]) : (a[gi] & b_eff[gi]));
      end
   endgenerate

   assign sum31 = sum[31];
   assign cout  = carry[32];

endmodule

// File: rtl/alu_sequencer.sv
// Single-command ALU sequencer: one-cycle logic/arith ops and a 32-cycle shift-add multiply
// sharing one ripple ALU, with a valid/ready command and response handshake.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_cout,
   output logic        rsp_err,
   output logic        busy
);

   state_t            state_reg, state_next;
   logic [2:0]        op_reg;
   logic [31:0]       a_reg;
   logic [31:0]       b_reg;
   logic [31:0]       acc_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [31:0]       result_reg;
   logic              zero_reg, cout_reg, err_reg;

   alu_ctrl_t         ctrl;
   logic [31:0]       alu_a, alu_b, alu_result;
   logic              alu_sum31, alu_cout;
   logic              lt;
   logic [31:0]       exec_result;
   logic [31:0]       acc_next;
   logic              last_iter;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   assign last_iter = (count_reg == LAST_ITER);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (cmd_valid) state_next = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
         S_EXEC: state_next = S_DONE;
         S_MUL:  if (last_iter) state_next = S_DONE;
         S_DONE: if (rsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // In MUL the ALU accumulates: acc + shifted multiplicand
   always_comb begin
      ctrl  = CTRL_AND;
      alu_a = a_reg;
      alu_b = b_reg;
      case (state_reg)
         S_EXEC: ctrl = ctrl_for_op(op_reg);
         S_MUL: begin
            ctrl  = CTRL_ADD;
            alu_a = acc_reg;
            alu_b = a_reg;
         end
         default: ;
      endcase
   end

   thirty_two_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op1    (ctrl.op1),
      .op2    (ctrl.op2),
      .sub    (ctrl.sub),
      .cin    (ctrl.cin),
      .less   (1'b0),
      .result (alu_result),
      .sum31  (alu_sum31),
      .cout   (alu_cout)
   );

   // Signed less-than from operand signs and the subtraction sign bit, overflow-safe
   assign lt = (a_reg[31] & ~b_reg[31]) | (~(a_reg[31] ^ b_reg[31]) & alu_sum31);

   always_comb begin
      exec_result = 32'd0;
      case (op_reg)
         OP_AND, OP_OR, OP_ADD, OP_SUB: exec_result = alu_result;
         OP_SLT:                        exec_result = {31'b0, lt};
         default:                       exec_result = 32'd0;
      endcase
   end

   assign acc_next = b_reg[0] ? alu_result : acc_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_reg     <= 3'd0;
         a_reg      <= 32'd0;
         b_reg      <= 32'd0;
         acc_reg    <= 32'd0;
         count_reg  <= '0;
         result_reg <= 32'd0;
         zero_reg   <= 1'b0;
         cout_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_reg    <= cmd_op;
                  a_reg     <= cmd_a;
                  b_reg     <= cmd_b;
                  acc_reg   <= 32'd0;
                  count_reg <= '0;
               end
            end
            S_EXEC: begin
               result_reg <= exec_result;
               zero_reg   <= (exec_result == 32'd0);
               cout_reg   <= op_legal(op_reg) ? alu_cout : 1'b0;
               err_reg    <= ~op_legal(op_reg);
            end
            S_MUL: begin
               acc_reg   <= acc_next;
               a_reg     <= a_reg << 1;
               b_reg     <= b_reg >> 1;
               count_reg <= count_reg + 1'b1;
               if (last_iter) begin
                  result_reg <= acc_next;
                  zero_reg   <= (acc_next == 32'd0);
                  cout_reg   <= 1'b0;
                  err_reg    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready  = (state_reg == S_IDLE);
   assign busy       = (state_reg != S_IDLE);
   assign rsp_valid  = (state_reg == S_DONE);
   assign rsp_result = result_reg;
   assign rsp_zero   = zero_reg;
   assign rsp_cout   = cout_reg;
   assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random commands against a reference model.
module tb_alu_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_cout;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_cout   (rsp_cout),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model from the opcode definitions, using plain wide arithmetic
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic z, output logic c,
                                 output logic e, output int lat);
      logic [32:0] wide;
      logic [63:0] prod;
      c   = 1'b0;
      e   = 1'b0;
      lat = 1;
      case (op)
         3'd0: begin r = a & b; wide = {1'b0, a} + {1'b0, b}; c = wide[32]; end
         3'd1: begin r = a | b; wide = {1'b0, a} + {1'b0, b}; c = wide[32]; end
         3'd2: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
         3'd3: begin r = a - b; c = (a >= b); end
         3'd4: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = (a >= b); end
         3'd5: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; lat = 32; end
         default: begin r = 32'd0; e = 1'b1; end
      endcase
      z = (r == 32'd0);
   endfunction

   task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke);
      logic [31:0] er;
      logic ez, ec, ee;
      int elat;
      int n;
      model(op, a, b, er, ez, ec, ee, elat);
      @(negedge clk);
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      n = 0;
      while (!rsp_valid && n < 100) begin
         check("busy_running", {30'd0, busy, cmd_ready}, 32'd2);
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", n, elat);
      check("result", rsp_result, er);
      check("flags", {29'd0, rsp_zero, rsp_cout, rsp_err}, {29'd0, ez, ec, ee});
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd2;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
         end
         @(posedge clk);
         #1;
         check("hold_result", rsp_result, er);
         check("hold_state", {29'd0, rsp_valid, cmd_ready, busy}, 32'd5);
         check("hold_flags", {29'd0, rsp_zero, rsp_cout, rsp_err}, {29'd0, ez, ec, ee});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("release_state", {29'd0, rsp_valid, cmd_ready, busy}, 32'd2);
      $display("txn op=%0d a=%h b=%h result=%h exp=%h lat=%0d hold=%0d", op, a, b, rsp_result, er, n, hold);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 32'd0;
      cmd_b     = 32'd0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("reset_outputs", {28'd0, busy, rsp_valid, rsp_zero, rsp_cout}, 32'd0);
      check("reset_err", {31'd0, rsp_err}, 32'd0);
      check("reset_result", rsp_result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      run_cmd(3'd2, 32'd40, 32'd10, 0, 1'b0);
      run_cmd(3'd3, 32'd40, 32'd40, 0, 1'b0);
      run_cmd(3'd4, 32'd10, 32'd40, 0, 1'b0);
      run_cmd(3'd4, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
      run_cmd(3'd5, 32'd400, 32'd100, 0, 1'b0);
      run_cmd(3'd1, 32'h0000_00F0, 32'h0000_000F, 5, 1'b1);
      run_cmd(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
      run_cmd(3'd6, 32'h0000_0001, 32'h0000_0002, 1, 1'b0);
      run_cmd(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0);
      run_cmd(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

      // Reset in the middle of a multiply
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_a     = 32'h0001_2345;
      cmd_b     = 32'h0000_7777;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midmul_reset_state", {30'd0, rsp_valid, busy}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midmul_release_ready", {30'd0, cmd_ready, busy}, 32'd2);
      check("midmul_release_result", rsp_result, 32'd0);
      run_cmd(3'd2, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [2:0] op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 5) == 0) a = 32'd0;
         run_cmd(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
